// File: rtl/bit_select_pkg.sv
// bit_select_pkg: shared select-table types and the identity-table reset helper.
//   TAB_WIDTH  data width the select table is built for
//   TAB_SW     select-index width, $clog2(TAB_WIDTH)
//   sel_t      one select-table entry
//   sel_tab_t  full select table, entry k drives output bit k
package bit_select_pkg;
    localparam int TAB_WIDTH = 4;
    localparam int TAB_SW    = $clog2(TAB_WIDTH);
    typedef logic [TAB_SW-1:0] sel_t;
    typedef sel_t [TAB_WIDTH-1:0] sel_tab_t;
    function automatic sel_tab_t identity_tab();
        sel_tab_t t;
        for (int k = 0; k < TAB_WIDTH; k++) t[k] = sel_t'(k);
        return t;
    endfunction
endpackage

// File: rtl/bit_select_fifo2.sv
// bit_select_fifo2: generic 2-entry valid/ready FIFO, registered head, no bubbles.
//   clk, rst              clock, synchronous active-high reset
//   in_valid/in_ready/d   push side; in_ready depends only on stored occupancy
//   out_valid/out_ready/q pop side; q is the head entry
//   count                 occupancy 0..2
module bit_select_fifo2 #(
    parameter int DW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] d,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] q,
    output logic [1:0]    count
);
    logic [DW-1:0] tail;
    logic          push;
    logic          pop;
    assign in_ready  = count != 2'd2;
    assign out_valid = count != 2'd0;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= 2'd0;
            q     <= '0;
            tail  <= '0;
        end else begin
            count <= count + 2'(push) - 2'(pop);
            // head takes new data when it is (or is about to become) empty; otherwise shifts from tail
            if ((count == 2'd0 && push) || (count == 2'd1 && push && pop))
                q <= d;
            else if (count == 2'd2 && pop)
                q <= tail;
            if (count == 2'd1 && push && !pop)
                tail <= d;
        end
    end
endmodule

// File: rtl/bit_select_stage.sv
// bit_select_stage: registered bit-permutation stage, O[k] = I[sel[k]], with a 2-entry output buffer.
//   CLK, RESET             clock, synchronous active-high reset
//   in_valid/in_ready/I    input beat handshake and data
//   out_valid/out_ready/O  output beat handshake and permuted data
//   cfg_we/cfg_idx/cfg_sel select-table write: sel[cfg_idx] = cfg_sel
//   beat_count             accepted input beats, modulo 2^CNTW
module bit_select_stage
    import bit_select_pkg::*;
#(
    parameter int WIDTH = TAB_WIDTH,
    parameter int CNTW  = 8,
    localparam int SW   = $clog2(WIDTH)
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [WIDTH-1:0] I,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [WIDTH-1:0] O,
    input  logic            cfg_we,
    input  logic [SW-1:0]   cfg_idx,
    input  logic [SW-1:0]   cfg_sel,
    output logic [CNTW-1:0] beat_count
);
    sel_tab_t         sel;
    logic [WIDTH-1:0] perm;
    logic [1:0]       occ;
    // permutation uses the table as it stands before this edge's write
    always_comb begin
        perm = '0;
        for (int k = 0; k < WIDTH; k++) perm[k] = I[sel[k]];
    end
    always_ff @(posedge CLK) begin
        if (RESET) begin
            sel        <= identity_tab();
            beat_count <= '0;
        end else begin
            if (cfg_we) sel[cfg_idx] <= cfg_sel;
            if (in_valid && occ != 2'd2) beat_count <= beat_count + 1'b1;
        end
    end
    bit_select_fifo2 #(.DW(WIDTH)) u_fifo (
        .clk       (CLK),
        .rst       (RESET),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .d         (perm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .q         (O),
        .count     (occ)
    );
endmodule

// File: tb/tb_bit_select_stage.sv
// tb_bit_select_stage: directed and randomized checks of bit_select_stage against a queue-based model.
module tb_bit_select_stage;
    localparam int WIDTH = 4;
    localparam int SW    = 2;
    localparam int CNTW  = 8;
    logic             CLK = 1'b0;
    logic             RESET = 1'b1;
    logic             in_valid = 1'b0;
    logic             out_ready = 1'b0;
    logic             cfg_we = 1'b0;
    logic [WIDTH-1:0] I = '0;
    logic [SW-1:0]    cfg_idx = '0;
    logic [SW-1:0]    cfg_sel = '0;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] O;
    logic [CNTW-1:0]  beat_count;
    int               n_cmp = 0;
    int               n_bad = 0;
    int               msel [WIDTH];
    logic [WIDTH-1:0] mq [$];
    int               mcnt = 0;
    bit               o_zero = 1'b1;

    bit_select_stage #(.WIDTH(WIDTH), .CNTW(CNTW)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .I          (I),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .O          (O),
        .cfg_we     (cfg_we),
        .cfg_idx    (cfg_idx),
        .cfg_sel    (cfg_sel),
        .beat_count (beat_count)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [WIDTH-1:0] model_perm(input logic [WIDTH-1:0] d);
        logic [WIDTH-1:0] r;
        for (int k = 0; k < WIDTH; k++) r[k] = d[msel[k]];
        return r;
    endfunction

    // one clock: advance the model at the edge, then compare on the falling edge
    task automatic tick();
        bit               rdy;
        bit               pop;
        logic [WIDTH-1:0] w;
        rdy = mq.size() != 2;
        @(posedge CLK);
        if (RESET) begin
            mq.delete();
            for (int k = 0; k < WIDTH; k++) msel[k] = k;
            mcnt   = 0;
            o_zero = 1'b1;
        end else begin
            w   = model_perm(I);
            pop = mq.size() != 0 && out_ready;
            if (pop) void'(mq.pop_front());
            if (in_valid && rdy) begin
                mq.push_back(w);
                mcnt   = (mcnt + 1) % (1 << CNTW);
                o_zero = 1'b0;
            end
            if (cfg_we) msel[cfg_idx] = int'(cfg_sel);
        end
        @(negedge CLK);
        chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
        chk("in_ready", 32'(in_ready), 32'(mq.size() != 2));
        chk("beat_count", 32'(beat_count), 32'(mcnt));
        if (mq.size() != 0) chk("O", 32'(O), 32'(mq[0]));
        else if (o_zero) chk("O_reset", 32'(O), 32'd0);
    endtask

    task automatic cfg(input int idx, input int s);
        cfg_we  = 1'b1;
        cfg_idx = SW'(idx);
        cfg_sel = SW'(s);
        tick();
        cfg_we = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < WIDTH; k++) msel[k] = k;
        tick();
        tick();
        RESET = 1'b0;
        tick();
        chk("reset_o", 32'(O), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);

        I = 4'b1010; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("identity_o", 32'(O), 32'b1010);
        chk("identity_cnt", 32'(beat_count), 32'd1);
        tick();

        cfg(3, 0); cfg(2, 0); cfg(1, 1); cfg(0, 2);
        I = 4'b0101; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("perm_o", 32'(O), 32'b1101);
        tick();

        RESET = 1'b1; tick(); RESET = 1'b0;
        out_ready = 1'b0; in_valid = 1'b1;
        I = 4'h3; tick();
        I = 4'h5; tick();
        chk("stall_in_ready", 32'(in_ready), 32'd0);
        I = 4'h9; tick(); tick();
        chk("stall_cnt", 32'(beat_count), 32'd2);
        chk("stall_head", 32'(O), 32'h3);
        out_ready = 1'b1; tick();
        chk("bp_b", 32'(O), 32'h5);
        tick();
        in_valid = 1'b0;
        chk("bp_c", 32'(O), 32'h9);
        chk("bp_cnt", 32'(beat_count), 32'd3);
        tick();

        cfg_we = 1'b1; cfg_idx = 2'd0; cfg_sel = 2'd3;
        I = 4'b1000; in_valid = 1'b1;
        tick();
        cfg_we = 1'b0;
        chk("same_cycle_old", 32'(O[0]), 32'd0);
        tick();
        in_valid = 1'b0;
        chk("same_cycle_new", 32'(O[0]), 32'd1);
        tick();

        out_ready = 1'b0; in_valid = 1'b1; I = 4'b0110;
        tick(); tick();
        chk("pre_reset_full", 32'(in_ready), 32'd0);
        RESET = 1'b1; cfg_we = 1'b1; cfg_idx = 2'd1; cfg_sel = 2'd0;
        tick();
        RESET = 1'b0; cfg_we = 1'b0; in_valid = 1'b0;
        chk("mid_reset_valid", 32'(out_valid), 32'd0);
        chk("mid_reset_ready", 32'(in_ready), 32'd1);
        chk("mid_reset_o", 32'(O), 32'd0);
        chk("mid_reset_cnt", 32'(beat_count), 32'd0);
        I = 4'b0011; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("post_reset_o", 32'(O), 32'b0011);
        tick();

        RESET = 1'b1; tick(); RESET = 1'b0;
        in_valid = 1'b1; out_ready = 1'b1;
        for (int n = 0; n < 256; n++) begin
            I = WIDTH'($urandom);
            tick();
        end
        chk("wrap_zero", 32'(beat_count), 32'd0);
        tick();
        chk("wrap_one", 32'(beat_count), 32'd1);

        for (int n = 0; n < 3000; n++) begin
            I         = WIDTH'($urandom);
            in_valid  = $urandom_range(0, 3) != 0;
            out_ready = $urandom_range(0, 2) != 0;
            cfg_we    = $urandom_range(0, 7) == 0;
            cfg_idx   = SW'($urandom);
            cfg_sel   = SW'($urandom);
            RESET     = $urandom_range(0, 149) == 0;
            tick();
        end
        RESET = 1'b0; cfg_we = 1'b0; in_valid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
